pe_simd_db: RTL

PE_SIMD_DB -- requirements
Module: pe_simd_db

---
 rtl/pe_simd_db_pkg.sv | 22 ++
 rtl/pe_simd_db_if.sv | 40 ++++
 rtl/pe_lane_mac.sv | 53 +++++
 rtl/pe_simd_db.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/pe_simd_db_pkg.sv
// pe_simd_db_pkg: shared definitions for the SIMD dual-bank processing element.
//   state_e  - controller states (IDLE, ACCUM, DONE, DRAIN)
//   sat_max  - largest signed value representable in <width> bits (LSB-aligned)
//   sat_min  - smallest signed value representable in <width> bits (LSB-aligned)
package pe_simd_db_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  function automatic logic [63:0] sat_max(input int unsigned width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int unsigned width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/pe_simd_db_if.sv
// pe_simd_db_if: operand/control/result bundle of the processing element.
//   Control : mode, os_drain, wgt_load, wgt_swap, in_valid, acc_len
//   Operands: act_data_in, wgt_data_in, result_in
//   Results : act_data_out, act_valid_out, result_out, out_valid, acc_done, sat_flag
// master = the side driving operands (array / bench), slave = the PE.
interface pe_simd_db_if #(
  parameter int unsigned ACT_WIDTH    = 8,
  parameter int unsigned WGT_WIDTH    = 8,
  parameter int unsigned PE_OUT_WIDTH = 32,
  parameter int unsigned LANES        = 2,
  parameter int unsigned CNT_WIDTH    = 8
);
  logic                          mode;
  logic                          os_drain;
  logic                          wgt_load;
  logic                          wgt_swap;
  logic                          in_valid;
  logic [LANES*ACT_WIDTH-1:0]    act_data_in;
  logic [LANES*WGT_WIDTH-1:0]    wgt_data_in;
  logic [PE_OUT_WIDTH-1:0]       result_in;
  logic [CNT_WIDTH-1:0]          acc_len;
  logic [LANES*ACT_WIDTH-1:0]    act_data_out;
  logic                          act_valid_out;
  logic [PE_OUT_WIDTH-1:0]       result_out;
  logic                          out_valid;
  logic                          acc_done;
  logic                          sat_flag;

  modport master (
    output mode, os_drain, wgt_load, wgt_swap, in_valid,
           act_data_in, wgt_data_in, result_in, acc_len,
    input  act_data_out, act_valid_out, result_out, out_valid, acc_done, sat_flag
  );

  modport slave (
    input  mode, os_drain, wgt_load, wgt_swap, in_valid,
           act_data_in, wgt_data_in, result_in, acc_len,
    output act_data_out, act_valid_out, result_out, out_valid, acc_done, sat_flag
  );
endinterface

// File: rtl/pe_lane_mac.sv
// pe_lane_mac: stage 1 of the PE. LANES signed multipliers, an adder tree
// at full precision, and the stage-1 sum/valid register.
//   clk, reset : clock, synchronous active-high reset
//   valid_i    : operands accepted this cycle
//   act_i      : packed signed activations, lane 0 in the LSBs
//   wgt_i      : packed signed weights, lane 0 in the LSBs
//   sum_o      : registered sum of lane products (SUM_W bits, signed)
//   valid_o    : registered valid_i
module pe_lane_mac #(
  parameter int unsigned ACT_WIDTH = 8,
  parameter int unsigned WGT_WIDTH = 8,
  parameter int unsigned LANES     = 2,
  parameter int unsigned SUM_W     = 17
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        valid_i,
  input  logic [LANES*ACT_WIDTH-1:0]  act_i,
  input  logic [LANES*WGT_WIDTH-1:0]  wgt_i,
  output logic signed [SUM_W-1:0]     sum_o,
  output logic                        valid_o
);
  localparam int unsigned PROD_W = ACT_WIDTH + WGT_WIDTH;

  logic signed [ACT_WIDTH-1:0] act_l  [LANES];
  logic signed [WGT_WIDTH-1:0] wgt_l  [LANES];
  logic signed [PROD_W-1:0]    prod_l [LANES];
  logic signed [SUM_W-1:0]     sum_d, sum_q;
  logic                        valid_q;

  always_comb begin
    sum_d = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      act_l[i]  = act_i[i*ACT_WIDTH +: ACT_WIDTH];
      wgt_l[i]  = wgt_i[i*WGT_WIDTH +: WGT_WIDTH];
      prod_l[i] = PROD_W'(act_l[i]) * PROD_W'(wgt_l[i]);
      sum_d     = sum_d + SUM_W'(prod_l[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) sum_q <= sum_d;
    end
  end

  assign sum_o   = sum_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/pe_simd_db.sv
// pe_simd_db: SIMD multiply-accumulate processing element with double-buffered
// weights, weight-stationary (WS) and output-stationary (OS) modes.
//   clk, reset : clock, synchronous active-high reset
//   bus        : pe_simd_db_if slave (operands, control, results)
// Stage 1 (pe_lane_mac) sums LANES products; stage 2 adds that sum to either
// the registered result_in (WS) or the accumulator (OS), with optional
// saturation. A small FSM sequences OS accumulation and the drain chain.
module pe_simd_db #(
  parameter int unsigned ACT_WIDTH    = 8,
  parameter int unsigned WGT_WIDTH    = 8,
  parameter int unsigned PE_OUT_WIDTH = 32,
  parameter int unsigned LANES        = 2,
  parameter int unsigned SATURATE     = 1,
  parameter int unsigned CNT_WIDTH    = 8
) (
  input logic         clk,
  input logic         reset,
  pe_simd_db_if.slave bus
);
  import pe_simd_db_pkg::*;

  localparam int unsigned SUM_W = ACT_WIDTH + WGT_WIDTH + $clog2(LANES);
  localparam int unsigned EXT_W = ((PE_OUT_WIDTH > SUM_W) ? PE_OUT_WIDTH : SUM_W) + 1;
  localparam logic [63:0] MAX64 = sat_max(PE_OUT_WIDTH);
  localparam logic [63:0] MIN64 = sat_min(PE_OUT_WIDTH);
  localparam logic [PE_OUT_WIDTH-1:0] OUT_MAX = MAX64[PE_OUT_WIDTH-1:0];
  localparam logic [PE_OUT_WIDTH-1:0] OUT_MIN = MIN64[PE_OUT_WIDTH-1:0];

  state_e                          state_q, state_d;
  logic                            mode_q, mode_d;
  logic [CNT_WIDTH-1:0]            cnt_q, cnt_d;
  logic                            first_q, first_d;
  logic                            sat_q, sat_d;
  logic signed [PE_OUT_WIDTH-1:0]  acc_q, acc_d;
  logic signed [PE_OUT_WIDTH-1:0]  rin_q;
  logic                            s1_os_q;
  logic                            out_vld_q;
  logic [LANES*WGT_WIDTH-1:0]      shadow_q, active_q;
  logic [LANES*ACT_WIDTH-1:0]      act_out_q;
  logic                            act_vld_q;

  logic                            cur_os, accept, complete, wr_en, ovf;
  logic [LANES*WGT_WIDTH-1:0]      wgt_sel;
  logic signed [SUM_W-1:0]         s1_sum;
  logic                            s1_valid;
  logic signed [PE_OUT_WIDTH-1:0]  operand;
  logic signed [EXT_W-1:0]         total;

  // The latched mode only updates in IDLE, so the IDLE cycle itself must look
  // at the live mode input to pick the weight source.
  assign cur_os   = (state_q == ST_IDLE) ? bus.mode : mode_q;
  assign accept   = bus.in_valid && !bus.os_drain &&
                    ((state_q == ST_IDLE) || (state_q == ST_ACCUM));
  assign wgt_sel  = cur_os ? bus.wgt_data_in : active_q;
  assign complete = (bus.acc_len != '0) && (cnt_q == bus.acc_len);

  pe_lane_mac #(
    .ACT_WIDTH (ACT_WIDTH),
    .WGT_WIDTH (WGT_WIDTH),
    .LANES     (LANES),
    .SUM_W     (SUM_W)
  ) u_lane_mac (
    .clk     (clk),
    .reset   (reset),
    .valid_i (accept),
    .act_i   (bus.act_data_in),
    .wgt_i   (wgt_sel),
    .sum_o   (s1_sum),
    .valid_o (s1_valid)
  );

  // OS writes are only allowed while accumulating and before the count is met;
  // anything landing during a drain is dropped.
  assign wr_en   = s1_valid && !bus.os_drain && (state_q != ST_DRAIN) &&
                   (!s1_os_q || ((state_q == ST_ACCUM) && !complete));
  assign operand = s1_os_q ? (first_q ? '0 : acc_q) : rin_q;
  assign total   = EXT_W'(operand) + EXT_W'(s1_sum);
  assign ovf     = (total[EXT_W-1:PE_OUT_WIDTH-1] != '0) &&
                   (total[EXT_W-1:PE_OUT_WIDTH-1] != '1);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    acc_d   = acc_q;
    sat_d   = sat_q;

    if (state_q == ST_IDLE) mode_d = bus.mode;

    unique case (state_q)
      ST_IDLE: begin
        if (accept && bus.mode) begin
          state_d = ST_ACCUM;
          cnt_d   = '0;
          first_d = 1'b1;
        end
      end
      ST_ACCUM: if (complete) state_d = ST_DONE;
      ST_DONE:  ;
      ST_DRAIN: if (!bus.os_drain) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (wr_en) begin
      if ((SATURATE != 0) && ovf) begin
        acc_d = total[EXT_W-1] ? OUT_MIN : OUT_MAX;
        sat_d = 1'b1;
      end else begin
        acc_d = total[PE_OUT_WIDTH-1:0];
      end
      if (s1_os_q) begin
        cnt_d   = cnt_q + 1'b1;
        first_d = 1'b0;
      end
    end

    if (bus.os_drain) begin
      state_d = ST_DRAIN;
      acc_d   = bus.result_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      mode_q    <= 1'b0;
      cnt_q     <= '0;
      first_q   <= 1'b0;
      sat_q     <= 1'b0;
      acc_q     <= '0;
      rin_q     <= '0;
      s1_os_q   <= 1'b0;
      out_vld_q <= 1'b0;
      shadow_q  <= '0;
      active_q  <= '0;
      act_out_q <= '0;
      act_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      first_q   <= first_d;
      sat_q     <= sat_d;
      acc_q     <= acc_d;
      out_vld_q <= wr_en;
      act_out_q <= bus.act_data_in;
      act_vld_q <= bus.in_valid;
      if (accept) begin
        rin_q   <= bus.result_in;
        s1_os_q <= cur_os;
      end
      // Non-blocking update gives load+swap the old shadow in the active bank.
      if (bus.wgt_load) shadow_q <= bus.wgt_data_in;
      if (bus.wgt_swap) active_q <= shadow_q;
    end
  end

  assign bus.act_data_out  = act_out_q;
  assign bus.act_valid_out = act_vld_q;
  assign bus.result_out    = acc_q;
  assign bus.out_valid     = out_vld_q;
  assign bus.acc_done      = (state_q == ST_DONE);
  assign bus.sat_flag      = sat_q;
endmodule
